plic_claim_engine: RTL and testbench

- AXI4-Lite master that runs the claim/complete sequence against the interrupt controller on behalf of the core.
- On a raised external interrupt line it reads the matching context's claim register and hands the claimed source ID to the trap logic.
- When the handler finishes, the core signals completion and the engine writes the ID back to the complete register.
- One claim outstanding at a time; M context takes priority over S.

---
 rtl/plic_claim_engine_pkg.sv | 33 +++
 rtl/plic_claim_engine.sv | 200 ++++++++++++++++++++
 tb/tb_plic_claim_engine.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/plic_claim_engine_pkg.sv
// Shared types and constants for the PLIC claim/complete engine.
// Holds the FSM state encoding, default claim offsets and AXI response codes.
package plic_claim_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_AR      = 3'd1,
        ST_R       = 3'd2,
        ST_PRESENT = 3'd3,
        ST_BUSY    = 3'd4,
        ST_WR      = 3'd5,
        ST_B       = 3'd6
    } state_e;

    localparam logic [31:0] PLIC_BASE_DEF  = 32'h0C00_0000;
    localparam logic [31:0] MCLAIM_OFS_DEF = 32'h0020_0004;
    localparam logic [31:0] SCLAIM_OFS_DEF = 32'h0020_1004;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic CTX_M = 1'b0;
    localparam logic CTX_S = 1'b1;

    // The same register serves as claim (read) and complete (write) for a context.
    function automatic logic [31:0] claim_addr(input logic [31:0] base,
                                               input logic [31:0] m_ofs,
                                               input logic [31:0] s_ofs,
                                               input logic        ctx);
        return base + ((ctx == CTX_S) ? s_ofs : m_ofs);
    endfunction

endpackage

// File: rtl/plic_claim_engine.sv
// AXI4-Lite master running the PLIC claim/complete handshake for one core.
// One claim in flight at a time; the M context wins over S when both are pending.
module plic_claim_engine
    import plic_claim_engine_pkg::*;
#(
    parameter logic [31:0] PLIC_BASE  = PLIC_BASE_DEF,
    parameter logic [31:0] MCLAIM_OFS = MCLAIM_OFS_DEF,
    parameter logic [31:0] SCLAIM_OFS = SCLAIM_OFS_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        external_intr_m,
    input  logic        external_intr_s,
    output logic [31:0] axi_araddr,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    output logic [2:0]  axi_arprot,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    output logic [31:0] axi_awaddr,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [2:0]  axi_awprot,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    input  logic [1:0]  axi_bresp,
    input  logic        axi_bvalid,
    output logic        axi_bready,
    output logic        claim_valid,
    output logic [31:0] claim_id,
    output logic        claim_ctx,
    input  logic        claim_ready,
    input  logic        complete_valid,
    output logic        complete_ready,
    output logic        bus_err
);

    state_e      state_q;
    logic        ctx_q;
    logic [31:0] addr_q;
    logic        idle_hold_q;
    logic        aw_done_q;
    logic        w_done_q;

    logic [31:0] araddr_q;
    logic        arvalid_q;
    logic        rready_q;
    logic [31:0] awaddr_q;
    logic        awvalid_q;
    logic [31:0] wdata_q;
    logic        wvalid_q;
    logic        bready_q;
    logic        claim_valid_q;
    logic [31:0] claim_id_q;
    logic        complete_ready_q;
    logic        bus_err_q;

    logic        sel_ctx;
    logic [31:0] sel_addr;
    logic        aw_hs;
    logic        w_hs;
    logic        aw_fin;
    logic        w_fin;

    assign sel_ctx  = external_intr_m ? CTX_M : CTX_S;
    assign sel_addr = claim_addr(PLIC_BASE, MCLAIM_OFS, SCLAIM_OFS, sel_ctx);

    // AW and W finish independently; a channel counts as done in its handshake cycle.
    assign aw_hs  = awvalid_q & axi_awready;
    assign w_hs   = wvalid_q & axi_wready;
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q | w_hs;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q          <= ST_IDLE;
            ctx_q            <= CTX_M;
            addr_q           <= '0;
            idle_hold_q      <= 1'b0;
            aw_done_q        <= 1'b0;
            w_done_q         <= 1'b0;
            araddr_q         <= '0;
            arvalid_q        <= 1'b0;
            rready_q         <= 1'b0;
            awaddr_q         <= '0;
            awvalid_q        <= 1'b0;
            wdata_q          <= '0;
            wvalid_q         <= 1'b0;
            bready_q         <= 1'b0;
            claim_valid_q    <= 1'b0;
            claim_id_q       <= '0;
            complete_ready_q <= 1'b0;
            bus_err_q        <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Skip one sample after a sequence so the PLIC can drop the level.
                    if (idle_hold_q) begin
                        idle_hold_q <= 1'b0;
                    end else if (external_intr_m || external_intr_s) begin
                        ctx_q     <= sel_ctx;
                        addr_q    <= sel_addr;
                        araddr_q  <= sel_addr;
                        arvalid_q <= 1'b1;
                        state_q   <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_R;
                    end
                end
                ST_R: begin
                    if (axi_rvalid) begin
                        rready_q <= 1'b0;
                        if (axi_rresp != RESP_OKAY) begin
                            bus_err_q   <= 1'b1;
                            idle_hold_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else if (axi_rdata == '0) begin
                            idle_hold_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            claim_id_q    <= axi_rdata;
                            claim_valid_q <= 1'b1;
                            state_q       <= ST_PRESENT;
                        end
                    end
                end
                ST_PRESENT: begin
                    if (claim_ready) begin
                        claim_valid_q    <= 1'b0;
                        complete_ready_q <= 1'b1;
                        state_q          <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (complete_valid) begin
                        complete_ready_q <= 1'b0;
                        awaddr_q         <= addr_q;
                        wdata_q          <= claim_id_q;
                        awvalid_q        <= 1'b1;
                        wvalid_q         <= 1'b1;
                        aw_done_q        <= 1'b0;
                        w_done_q         <= 1'b0;
                        state_q          <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_B;
                    end
                end
                ST_B: begin
                    if (axi_bvalid) begin
                        bready_q    <= 1'b0;
                        bus_err_q   <= (axi_bresp != RESP_OKAY);
                        idle_hold_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign axi_araddr     = araddr_q;
    assign axi_arvalid    = arvalid_q;
    assign axi_arprot     = 3'b000;
    assign axi_rready     = rready_q;
    assign axi_awaddr     = awaddr_q;
    assign axi_awvalid    = awvalid_q;
    assign axi_awprot     = 3'b000;
    assign axi_wdata      = wdata_q;
    assign axi_wstrb      = 4'hF;
    assign axi_wvalid     = wvalid_q;
    assign axi_bready     = bready_q;
    assign claim_valid    = claim_valid_q;
    assign claim_id       = claim_id_q;
    assign claim_ctx      = ctx_q;
    assign complete_ready = complete_ready_q;
    assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_plic_claim_engine.sv
// Directed plus randomized bench for plic_claim_engine; the bench plays the AXI slave and the core,
// and predicts addresses, IDs and handshake timing from the claim/complete rules.
module tb_plic_claim_engine;

    logic        clk = 1'b0;
    logic        rstn;
    logic        external_intr_m, external_intr_s;
    logic [31:0] axi_araddr;
    logic        axi_arvalid, axi_arready;
    logic [2:0]  axi_arprot;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid, axi_rready;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid, axi_awready;
    logic [2:0]  axi_awprot;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid, axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid, axi_bready;
    logic        claim_valid;
    logic [31:0] claim_id;
    logic        claim_ctx;
    logic        claim_ready;
    logic        complete_valid, complete_ready;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    plic_claim_engine dut (
        .clk(clk), .rstn(rstn),
        .external_intr_m(external_intr_m), .external_intr_s(external_intr_s),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_arprot(axi_arprot),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_awprot(axi_awprot),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .claim_valid(claim_valid), .claim_id(claim_id), .claim_ctx(claim_ctx),
        .claim_ready(claim_ready),
        .complete_valid(complete_valid), .complete_ready(complete_ready),
        .bus_err(bus_err)
    );

    // Claim/complete register address of a context: 0 = M, 1 = S.
    function automatic logic [31:0] ref_addr(input bit ctx);
        return 32'h0C00_0000 + (ctx ? 32'h0020_1004 : 32'h0020_0004);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise lines, serve the claim read, and check what reaches the core.
    task automatic do_claim(input bit m, input bit s, input logic [31:0] id,
                            input logic [1:0] rresp, input int ar_dly, input int r_dly,
                            input int exp_wait, output bit presented);
        bit          ectx;
        int          n;
        int          t0;
        logic [31:0] ad;
        ectx = m ? 1'b0 : 1'b1;
        external_intr_m = m;
        external_intr_s = s;
        t0 = cyc;
        n  = 0;
        presented = 1'b0;
        while (!axi_arvalid && n < 10) begin
            tick();
            n++;
        end
        chk("ar_seen", {31'd0, axi_arvalid}, 32'd1);
        if (!axi_arvalid) begin
            external_intr_m = 1'b0;
            external_intr_s = 1'b0;
            return;
        end
        if (exp_wait > 0) chk("ar_latency", n, exp_wait);
        chk("araddr", axi_araddr, ref_addr(ectx));
        chk("arprot", {29'd0, axi_arprot}, 32'd0);
        ad = axi_araddr;
        // Lines wander while the claim is in flight; the latched context must not move.
        external_intr_m = 1'($urandom);
        external_intr_s = 1'($urandom);
        repeat (ar_dly) begin
            tick();
            chk("ar_hold", {30'd0, axi_arvalid, axi_rready}, 32'b10);
            chk("ar_addr_stable", axi_araddr, ad);
        end
        axi_arready = 1'b1;
        tick();
        axi_arready = 1'b0;
        chk("r_phase", {30'd0, axi_arvalid, axi_rready}, 32'b01);
        repeat (r_dly) begin
            tick();
            chk("r_hold", {31'd0, axi_rready}, 32'd1);
        end
        external_intr_m = 1'b0;
        external_intr_s = 1'b0;
        axi_rvalid = 1'b1;
        axi_rdata  = id;
        axi_rresp  = rresp;
        tick();
        axi_rvalid = 1'b0;
        axi_rdata  = $urandom;
        axi_rresp  = 2'b00;
        presented = (rresp == 2'b00) && (id != 32'd0);
        chk("rready_drop", {31'd0, axi_rready}, 32'd0);
        chk("bus_err_r", {31'd0, bus_err}, {31'd0, rresp != 2'b00});
        chk("claim_valid", {31'd0, claim_valid}, {31'd0, presented});
        if (presented) begin
            chk("claim_id", claim_id, id);
            chk("claim_ctx", {31'd0, claim_ctx}, {31'd0, ectx});
            if (ar_dly == 0 && r_dly == 0 && exp_wait == 1) chk("claim_latency", cyc - t0, 3);
        end
        tick();
        chk("bus_err_pulse", {31'd0, bus_err}, 32'd0);
        if (!presented) chk("no_present", {31'd0, claim_valid}, 32'd0);
    endtask

    task automatic do_present(input logic [31:0] id, input bit ctx, input int dly);
        repeat (dly) begin
            tick();
            chk("cv_hold", {31'd0, claim_valid}, 32'd1);
            chk("cid_stable", claim_id, id);
            chk("cctx_stable", {31'd0, claim_ctx}, {31'd0, ctx});
            chk("cr_low", {31'd0, complete_ready}, 32'd0);
        end
        claim_ready = 1'b1;
        tick();
        claim_ready = 1'b0;
        chk("cv_drop", {31'd0, claim_valid}, 32'd0);
        chk("busy_cready", {31'd0, complete_ready}, 32'd1);
    endtask

    task automatic do_complete(input logic [31:0] id, input bit ctx, input int c_dly,
                               input int aw_dly, input int w_dly, input int b_dly,
                               input logic [1:0] bresp, input bit keep_s);
        int       mx;
        bit [2:0] e;
        repeat (c_dly) begin
            tick();
            chk("cr_hold", {31'd0, complete_ready}, 32'd1);
            chk("no_aw_yet", {31'd0, axi_awvalid}, 32'd0);
        end
        complete_valid = 1'b1;
        tick();
        complete_valid = 1'b0;
        chk("cready_drop", {31'd0, complete_ready}, 32'd0);
        chk("wr_start", {29'd0, axi_awvalid, axi_wvalid, axi_bready}, 32'b110);
        chk("awaddr", axi_awaddr, ref_addr(ctx));
        chk("wdata", axi_wdata, id);
        chk("wstrb", {28'd0, axi_wstrb}, 32'hF);
        chk("awprot", {29'd0, axi_awprot}, 32'd0);
        mx = (aw_dly > w_dly) ? aw_dly : w_dly;
        for (int k = 0; k <= mx; k++) begin
            axi_awready = (k == aw_dly);
            axi_wready  = (k == w_dly);
            tick();
            e = {k < aw_dly, k < w_dly, k >= mx};
            chk("wr_chan", {29'd0, axi_awvalid, axi_wvalid, axi_bready}, {29'd0, e});
        end
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        repeat (b_dly) begin
            tick();
            chk("b_hold", {31'd0, axi_bready}, 32'd1);
        end
        axi_bvalid = 1'b1;
        axi_bresp  = bresp;
        if (keep_s) external_intr_s = 1'b1;
        tick();
        axi_bvalid = 1'b0;
        axi_bresp  = 2'b00;
        chk("bready_drop", {31'd0, axi_bready}, 32'd0);
        chk("bus_err_b", {31'd0, bus_err}, {31'd0, bresp != 2'b00});
        tick();
        chk("bus_err_b_pulse", {31'd0, bus_err}, 32'd0);
        // One quiet IDLE cycle: a line still high must not be sampled yet.
        chk("idle_hold", {27'd0, axi_arvalid, axi_awvalid, axi_wvalid, claim_valid, complete_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          p;
        bit          m, s, ctx;
        logic [31:0] id;
        logic [1:0]  rr, br;

        rstn = 1'b0;
        external_intr_m = 1'b0; external_intr_s = 1'b0;
        axi_arready = 1'b0; axi_rdata = '0; axi_rresp = 2'b00; axi_rvalid = 1'b0;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bresp = 2'b00; axi_bvalid = 1'b0;
        claim_ready = 1'b0; complete_valid = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_valids", {24'd0, axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready,
                           claim_valid, complete_ready, bus_err}, 32'd0);
        chk("rst_araddr", axi_araddr, 32'd0);
        chk("rst_awaddr", axi_awaddr, 32'd0);
        chk("rst_wdata", axi_wdata, 32'd0);
        chk("rst_claim_id", claim_id, 32'd0);
        chk("rst_claim_ctx", {31'd0, claim_ctx}, 32'd0);
        rstn = 1'b1;
        tick();

        // Basic M claim, zero-wait slave
        do_claim(1'b1, 1'b0, 32'd10, 2'b00, 0, 0, 1, p);
        do_present(32'd10, 1'b0, 0);
        do_complete(32'd10, 1'b0, 0, 0, 0, 0, 2'b00, 1'b0);

        // Both pending: M first; S left high into the completion, then claimed as S
        do_claim(1'b1, 1'b1, 32'd7, 2'b00, 1, 2, 0, p);
        do_present(32'd7, 1'b0, 2);
        do_complete(32'd7, 1'b0, 1, 0, 0, 1, 2'b00, 1'b1);
        do_claim(1'b0, 1'b1, 32'd33, 2'b00, 0, 0, 1, p);
        do_present(32'd33, 1'b1, 1);
        do_complete(32'd33, 1'b1, 0, 1, 2, 0, 2'b00, 1'b0);

        // Spurious claim: nothing presented, nothing written
        do_claim(1'b0, 1'b1, 32'd0, 2'b00, 0, 1, 0, p);
        repeat (3) begin
            tick();
            chk("spurious_quiet", {28'd0, axi_arvalid, axi_awvalid, axi_wvalid, claim_valid}, 32'd0);
        end

        // Read error, then write error
        do_claim(1'b1, 1'b0, 32'd5, 2'b10, 0, 0, 0, p);
        tick();
        do_claim(1'b1, 1'b0, 32'd6, 2'b00, 0, 0, 0, p);
        do_present(32'd6, 1'b0, 0);
        do_complete(32'd6, 1'b0, 0, 0, 0, 2, 2'b10, 1'b0);

        // AW delayed by three cycles, W immediate
        do_claim(1'b0, 1'b1, 32'd21, 2'b00, 0, 0, 0, p);
        do_present(32'd21, 1'b1, 0);
        do_complete(32'd21, 1'b1, 0, 3, 0, 0, 2'b00, 1'b0);

        // Reset while presenting, then a fresh claim
        do_claim(1'b1, 1'b0, 32'd44, 2'b00, 0, 0, 0, p);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("rst_present", {29'd0, claim_valid, complete_ready, axi_arvalid}, 32'd0);
        do_claim(1'b1, 1'b0, 32'd45, 2'b00, 0, 0, 1, p);
        do_present(32'd45, 1'b0, 0);
        do_complete(32'd45, 1'b0, 0, 0, 0, 0, 2'b00, 1'b0);

        // Randomized sequences
        for (int it = 0; it < 16; it++) begin
            m  = 1'($urandom);
            s  = m ? 1'($urandom) : 1'b1;
            ctx = m ? 1'b0 : 1'b1;
            id = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            rr = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00;
            br = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00;
            do_claim(m, s, id, rr, $urandom_range(0, 3), $urandom_range(0, 3), 0, p);
            if (p) begin
                do_present(id, ctx, $urandom_range(0, 3));
                do_complete(id, ctx, $urandom_range(0, 3), $urandom_range(0, 3),
                            $urandom_range(0, 3), $urandom_range(0, 3), br, 1'b0);
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
